// File: rtl/wishbone_burst_ram.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : wishbone_burst_ram
// Description : Single-port 32-bit Wishbone B3 slave RAM with registered-
//               feedback bursts (classic, constant-address, linear and
//               wrap-4/8/16 incrementing), byte-lane writes and error
//               response for out-of-range words.
// Ports       : i_clock  bus clock, all state changes on its rising edge
//               i_reset  synchronous active-high reset (memory untouched)
//               i_cyc/i_stb/i_we   Wishbone cycle, strobe, write enable
//               i_adr    byte address (word index = i_adr[31:2])
//               i_dat    write data, i_sel byte-lane enables
//               i_cti    cycle type, i_bte burst wrap type
//               o_dat    read data (zero unless o_ack)
//               o_ack    beat completed, o_err beat terminated with error
// Revision    : 1.0 - initial release
// ============================================================================
module wishbone_burst_ram #(
  parameter int    MEM_WORDS = 1024,
  parameter string INIT_FILE = ""
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_cyc,
  input  logic        i_stb,
  input  logic        i_we,
  input  logic [31:0] i_adr,
  input  logic [31:0] i_dat,
  input  logic [3:0]  i_sel,
  input  logic [2:0]  i_cti,
  input  logic [1:0]  i_bte,
  output logic [31:0] o_dat,
  output logic        o_ack,
  output logic        o_err
);

  localparam int          c_AW          = $clog2(MEM_WORDS);
  localparam logic [31:0] c_WORDS       = 32'(MEM_WORDS);
  localparam logic [2:0]  c_CTI_CLASSIC = 3'b000;
  localparam logic [2:0]  c_CTI_CONST   = 3'b001;
  localparam logic [2:0]  c_CTI_INCR    = 3'b010;
  localparam logic [2:0]  c_CTI_END     = 3'b111;
  localparam logic [1:0]  c_BTE_LINEAR  = 2'b00;
  localparam logic [1:0]  c_BTE_WRAP4   = 2'b01;
  localparam logic [1:0]  c_BTE_WRAP8   = 2'b10;
  localparam logic [1:0]  c_BTE_WRAP16  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CLASSIC = 2'd1,
    S_BURST   = 2'd2,
    S_ERROR   = 2'd3
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [c_AW-1:0] r_addr, w_addr_nxt, w_addr_inc, w_addr_step;
  logic            r_armed, w_armed_nxt;
  logic            r_ovf, w_ovf_nxt;
  logic            w_req, w_in_range, w_ack, w_err, w_wr;
  logic            w_unused_adr;
  logic [31:0]     r_mem [MEM_WORDS];

  assign w_req        = i_cyc & i_stb;
  assign w_in_range   = ({2'b00, i_adr[31:2]} < c_WORDS);
  assign w_unused_adr = ^i_adr[1:0];
  assign w_addr_inc   = r_addr + 1'b1;

  // Wrapping bursts keep the upper address bits and let only the low
  // 2/3/4 bits of the incremented value through.
  always_comb begin
    w_addr_step = w_addr_inc;
    case (i_bte)
      c_BTE_LINEAR: w_addr_step = w_addr_inc;
      c_BTE_WRAP4:  w_addr_step = {r_addr[c_AW-1:2], w_addr_inc[1:0]};
      c_BTE_WRAP8:  w_addr_step = {r_addr[c_AW-1:3], w_addr_inc[2:0]};
      c_BTE_WRAP16: w_addr_step = {r_addr[c_AW-1:4], w_addr_inc[3:0]};
      default:      w_addr_step = w_addr_inc;
    endcase
  end

  // r_armed: a beat response is owed in the current BURST cycle. It follows
  // the strobe of the previous cycle, so a wait state costs one extra cycle
  // after stb returns. r_ovf: a linear burst stepped past the last word, so
  // the next beat must be answered with err.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_armed_nxt = r_armed;
    w_ovf_nxt   = r_ovf;
    w_ack       = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_armed_nxt = 1'b1;
          w_ovf_nxt   = 1'b0;
          if (!w_in_range) begin
            w_state_nxt = S_ERROR;
          end else begin
            w_addr_nxt = i_adr[c_AW+1:2];
            if (i_cti == c_CTI_CLASSIC || i_cti == c_CTI_END)
              w_state_nxt = S_CLASSIC;
            else
              w_state_nxt = S_BURST;
          end
        end
      end
      S_CLASSIC: begin
        w_ack       = w_req;
        w_armed_nxt = 1'b0;
        w_state_nxt = S_IDLE;
      end
      S_ERROR: begin
        w_err       = w_req;
        w_armed_nxt = 1'b0;
        w_state_nxt = S_IDLE;
      end
      S_BURST: begin
        w_armed_nxt = w_req;
        if (r_armed && w_req) begin
          if (r_ovf) begin
            w_err       = 1'b1;
            w_armed_nxt = 1'b0;
            w_state_nxt = S_IDLE;
          end else begin
            w_ack = 1'b1;
            case (i_cti)
              c_CTI_INCR: begin
                w_addr_nxt = w_addr_step;
                if (i_bte == c_BTE_LINEAR && (&r_addr))
                  w_ovf_nxt = 1'b1;
              end
              c_CTI_CONST: w_addr_nxt = r_addr;
              // end-of-burst, or any other type ends the burst after this beat
              default: begin
                w_armed_nxt = 1'b0;
                w_state_nxt = S_IDLE;
              end
            endcase
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Master abort: drop everything, nothing further is acked or written.
    if (!i_cyc) begin
      w_state_nxt = S_IDLE;
      w_armed_nxt = 1'b0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_armed <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_armed <= w_armed_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  // A beat caught by reset is abandoned rather than committed.
  assign w_wr = w_ack & i_we & ~i_reset;

  always_ff @(posedge i_clock) begin
    if (w_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (i_sel[b])
          r_mem[r_addr][8*b +: 8] <= i_dat[8*b +: 8];
      end
    end
  end

  // Asynchronous read so a word written on one beat is visible on the next.
  assign o_dat = w_ack ? r_mem[r_addr] : 32'h0;
  assign o_ack = w_ack;
  assign o_err = w_err;

endmodule
`default_nettype wire

// File: doc/wishbone_burst_ram.md
WISHBONE_BURST_RAM -- requirements
Module: wishbone_burst_ram

Interface
REQ-001 Parameter MEM_WORDS, default 1024, SHALL set the number of 32-bit words (power of two, 16..65536).
REQ-002 Parameter INIT_FILE, default "", SHALL name a hex image loaded at elaboration; empty means contents are undefined.
REQ-003 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-004 clock  in  1  bus clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 cyc  in  1  Wishbone B3 cycle valid.
REQ-007 stb  in  1  strobe; a beat is requested when cyc&stb.
REQ-008 we  in  1  1 = write, 0 = read.
REQ-009 adr  in  32  byte address; word index = adr[31:2].
REQ-010 dat_i  in  32  write data.
REQ-011 sel  in  4  byte-lane enables; sel[n] covers dat bits 8n+7..8n.
REQ-012 cti  in  3  cycle type: 000 classic, 001 constant-address burst, 010 incrementing burst, 111 end-of-burst.
REQ-013 bte  in  2  burst wrap: 00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16.
REQ-014 dat_o  out  32  read data, valid only while ack=1.
REQ-015 ack  out  1  beat completed normally.
REQ-016 err  out  1  beat terminated with error.

Function
REQ-017 The FSM SHALL have states IDLE, CLASSIC, BURST and ERROR.
REQ-018 IDLE: on cyc&stb with word index < MEM_WORDS, go to CLASSIC if cti is 000 or 111, else to BURST; latch word index into the internal address counter (addr_q).
REQ-019 IDLE: on cyc&stb with word index >= MEM_WORDS, go to ERROR.
REQ-020 First-beat latency SHALL be exactly 1 cycle: ack (or err) is asserted in the cycle after the request is first seen.
REQ-021 CLASSIC: assert ack for exactly 1 cycle, then return to IDLE; back-to-back classic beats therefore cost 2 cycles each.
REQ-022 ERROR: assert err for exactly 1 cycle with ack=0 and no memory write, then return to IDLE.
REQ-023 BURST: while cyc&stb, assert ack every cycle (1 beat/cycle); after each acked beat, update addr_q per REQ-024/025.
REQ-024 cti=010: next addr_q = addr_q+1 for bte=00; for bte=01/10/11, increment only the low 2/3/4 bits modulo 4/8/16, with upper bits unchanged.
REQ-025 cti=001: addr_q SHALL be unchanged between beats.
REQ-026 After the first beat of a burst, adr SHALL be ignored and addr_q used.
REQ-027 A beat acked while cti=111 is the last beat: return to IDLE the next cycle with ack=0.
REQ-028 Linear increment past MEM_WORDS-1 SHALL give err (not ack) on that beat, then return to IDLE.
REQ-029 Wait state: stb=0 while cyc=1 in BURST drops ack the next cycle and holds addr_q. On stb re-assertion, ack resumes after 1 cycle.
REQ-030 Abort: cyc=0 in any state SHALL return to IDLE the next cycle with ack=err=0, and any beat not yet acked SHALL NOT be written.
REQ-031 A write SHALL be committed on the rising edge where ack=1 and we=1, only to the lanes with sel=1, at addr_q. sel=0000 writes nothing but is still acked.
REQ-032 Reads SHALL present mem[addr_q] on dat_o in the ack cycle. dat_o SHALL be 0 when ack=0.
REQ-033 Read-after-write to the same word in consecutive beats SHALL return the newly written data.
REQ-034 ack and err SHALL never be high in the same cycle.

Reset
REQ-035 On reset=1 at a rising edge, the FSM SHALL go to IDLE and ack, err, dat_o and addr_q SHALL be 0 from the next cycle, including in the middle of a burst.
REQ-036 Memory contents SHALL NOT be altered by reset.

Verification
REQ-037 Classic write then read: write 0xDEADBEEF, sel=1111, adr=0x10, then read adr=0x10 -> each transfer acked after 1 cycle with a 1-cycle ack pulse; read returns 0xDEADBEEF.
REQ-038 Byte lanes: mem[4]=0x11223344, write 0xAABBCCDD with sel=0101 -> read returns 0x11BB33DD.
REQ-039 Wrap-4 incrementing read burst: start adr=0x0C (word 3), cti=010, bte=01, 4 beats with the last beat cti=111 -> words 3,0,1,2 returned on 4 consecutive ack cycles; IDLE afterwards.
REQ-040 Wait state and abort: linear burst from word 8; stb=0 for 2 cycles after beat 2; cyc=0 during beat 4 before its ack -> beats 1..3 hit words 8,9,10; ack resumes 1 cycle after stb returns; word 11 is not written.
REQ-041 Error: classic read at word MEM_WORDS -> single-cycle err with ack=0 and dat_o=0; a linear burst at word MEM_WORDS-1 -> ack, then err on the next beat.
REQ-042 Reset mid-burst: reset=1 during beat 2 of a write burst -> ack=0 the next cycle, FSM in IDLE, beat-1 data retained in memory.
